// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU function codes, instruction encodings and sequencer state types
package alu_pkg;

    localparam logic [2:0] F_ADD  = 3'b000;
    localparam logic [2:0] F_SUB  = 3'b001;
    localparam logic [2:0] F_AND  = 3'b010;
    localparam logic [2:0] F_OR   = 3'b011;
    localparam logic [2:0] F_XOR  = 3'b100;
    localparam logic [2:0] F_SLT  = 3'b101;
    localparam logic [2:0] F_NONE = 3'b111;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Branch outcome is resolved purely from the ALU Zero flag
    localparam logic [1:0] BR_NONE     = 2'd0;
    localparam logic [1:0] BR_ON_ZERO  = 2'd1;
    localparam logic [1:0] BR_ON_NZERO = 2'd2;

    // Returns {valid, f}; f is F_NONE whenever valid is 0
    function automatic logic [3:0] arith_map(input logic [2:0] funct3, input logic alt);
        logic [3:0] m;
        case (funct3)
            F3_ADD:  m = {1'b1, alt ? F_SUB : F_ADD};
            F3_SLT:  m = {1'b1, F_SLT};
            F3_XOR:  m = {1'b1, F_XOR};
            F3_OR:   m = {1'b1, F_OR};
            F3_AND:  m = {1'b1, F_AND};
            default: m = {1'b0, F_NONE};
        endcase
        return m;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - combinational instruction decode to ALU function, operand select and branch kind
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [2:0] f,
    output logic       use_imm,
    output logic [1:0] br_kind,
    output logic       illegal
);

    logic [3:0] m_r;
    logic [3:0] m_i;

    always_comb begin
        m_r     = arith_map(funct3, funct7[5]);
        m_i     = arith_map(funct3, 1'b0);
        f       = F_NONE;
        use_imm = 1'b0;
        br_kind = BR_NONE;
        illegal = 1'b1;
        case (opcode)
            OP_R: begin
                if (funct7 == F7_BASE || funct7 == F7_ALT) begin
                    f       = m_r[2:0];
                    illegal = !m_r[3];
                end
            end
            OP_I: begin
                f       = m_i[2:0];
                illegal = !m_i[3];
                use_imm = 1'b1;
            end
            OP_LOAD, OP_STORE: begin
                f       = F_ADD;
                use_imm = 1'b1;
                illegal = 1'b0;
            end
            OP_BRANCH: begin
                // BLT/BGE use SLT: result 1 (Zero clear) means rs1 < rs2
                case (funct3)
                    F3_BEQ: begin f = F_SUB; br_kind = BR_ON_ZERO;  illegal = 1'b0; end
                    F3_BNE: begin f = F_SUB; br_kind = BR_ON_NZERO; illegal = 1'b0; end
                    F3_BLT: begin f = F_SLT; br_kind = BR_ON_NZERO; illegal = 1'b0; end
                    F3_BGE: begin f = F_SLT; br_kind = BR_ON_ZERO;  illegal = 1'b0; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - request/response sequencer driving a combinational 3-bit-function ALU
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_instr,
    input  logic [31:0]      req_rs1,
    input  logic [31:0]      req_rs2,
    input  logic [31:0]      req_imm,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [2:0]       alu_f,
    input  logic [31:0]      alu_result,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic             rsp_taken,
    output logic             rsp_illegal,
    output logic [CNT_W-1:0] op_count,
    output logic [CNT_W-1:0] illegal_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t     state_q;
    state_t     state_d;
    logic       load;
    logic       capture;
    logic [2:0] dec_f;
    logic       dec_use_imm;
    logic [1:0] dec_br;
    logic       dec_illegal;
    logic [1:0] br_q;
    logic       illegal_q;
    logic       taken_d;
    logic       unused_instr_bits;

    assign unused_instr_bits = ^{req_instr[24:15], req_instr[11:7]};

    alu_op_decode u_decode (
        .opcode  (req_instr[6:0]),
        .funct3  (req_instr[14:12]),
        .funct7  (req_instr[31:25]),
        .f       (dec_f),
        .use_imm (dec_use_imm),
        .br_kind (dec_br),
        .illegal (dec_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        load      = 1'b0;
        capture   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    load    = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                capture = 1'b1;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    // Retiring a response frees the slot for a request in the same cycle
                    req_ready = 1'b1;
                    if (req_valid) begin
                        load    = 1'b1;
                        state_d = ST_EXEC;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        taken_d = 1'b0;
        if (!illegal_q) begin
            if (br_q == BR_ON_ZERO) begin
                taken_d = alu_zero;
            end else if (br_q == BR_ON_NZERO) begin
                taken_d = !alu_zero;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a         <= '0;
            alu_b         <= '0;
            alu_f         <= F_NONE;
            br_q          <= BR_NONE;
            illegal_q     <= 1'b0;
            rsp_data      <= '0;
            rsp_taken     <= 1'b0;
            rsp_illegal   <= 1'b0;
            op_count      <= '0;
            illegal_count <= '0;
        end else begin
            if (load) begin
                alu_a     <= req_rs1;
                alu_b     <= dec_use_imm ? req_imm : req_rs2;
                alu_f     <= dec_f;
                br_q      <= dec_br;
                illegal_q <= dec_illegal;
            end
            if (capture) begin
                rsp_data    <= illegal_q ? 32'd0 : alu_result;
                rsp_taken   <= taken_d;
                rsp_illegal <= illegal_q;
            end
            if (rsp_valid && rsp_ready) begin
                op_count <= op_count + CNT_ONE;
                if (rsp_illegal) begin
                    illegal_count <= illegal_count + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - self-checking bench for alu_op_sequencer with a behavioural ALU
module tb_alu_op_sequencer;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [31:0]   req_instr = '0;
    logic [31:0]   req_rs1 = '0;
    logic [31:0]   req_rs2 = '0;
    logic [31:0]   req_imm = '0;
    logic [31:0]   alu_a;
    logic [31:0]   alu_b;
    logic [2:0]    alu_f;
    logic [31:0]   alu_result;
    logic          alu_zero;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [31:0]   rsp_data;
    logic          rsp_taken;
    logic          rsp_illegal;
    logic [CW-1:0] op_count;
    logic [CW-1:0] illegal_count;

    int checks = 0;
    int failures = 0;
    logic [CW-1:0] exp_ops = '0;
    logic [CW-1:0] exp_ill = '0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.CNT_W(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_instr     (req_instr),
        .req_rs1       (req_rs1),
        .req_rs2       (req_rs2),
        .req_imm       (req_imm),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_f         (alu_f),
        .alu_result    (alu_result),
        .alu_zero      (alu_zero),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_taken     (rsp_taken),
        .rsp_illegal   (rsp_illegal),
        .op_count      (op_count),
        .illegal_count (illegal_count)
    );

    always_comb begin
        case (alu_f)
            3'b000:  alu_result = alu_a + alu_b;
            3'b001:  alu_result = alu_a - alu_b;
            3'b010:  alu_result = alu_a & alu_b;
            3'b011:  alu_result = alu_a | alu_b;
            3'b100:  alu_result = alu_a ^ alu_b;
            3'b101:  alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            default: alu_result = 32'd0;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        return {f7, 10'd0, f3, 5'd0, op};
    endfunction

    // Arithmetic on funct3 for R/I forms; returns {ok, value}
    function automatic logic [32:0] arith(input logic [2:0] f3, input logic sub, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0:    return {1'b1, sub ? a - b : a + b};
            3'd2:    return {1'b1, 31'd0, $signed(a) < $signed(b)};
            3'd4:    return {1'b1, a ^ b};
            3'd6:    return {1'b1, a | b};
            3'd7:    return {1'b1, a & b};
            default: return 33'd0;
        endcase
    endfunction

    // Returns {illegal, taken, data} from instruction semantics
    function automatic logic [33:0] ref_op(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [32:0] r;
        logic        lt;
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        lt = $signed(a) < $signed(b);
        if (op == 7'h33) begin
            if (f7 != 7'h00 && f7 != 7'h20) return {1'b1, 33'd0};
            r = arith(f3, f7 == 7'h20, a, b);
            return r[32] ? {2'b00, r[31:0]} : {1'b1, 33'd0};
        end
        if (op == 7'h13) begin
            r = arith(f3, 1'b0, a, imm);
            return r[32] ? {2'b00, r[31:0]} : {1'b1, 33'd0};
        end
        if (op == 7'h03 || op == 7'h23) return {2'b00, a + imm};
        if (op == 7'h63) begin
            case (f3)
                3'd0:    return {1'b0, a == b, a - b};
                3'd1:    return {1'b0, a != b, a - b};
                3'd4:    return {1'b0, lt, 31'd0, lt};
                3'd5:    return {1'b0, !lt, 31'd0, lt};
                default: return {1'b1, 33'd0};
            endcase
        end
        return {1'b1, 33'd0};
    endfunction

    task automatic run_op(input string name, input logic [31:0] ins, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] imm, input int hold);
        logic [33:0] e;
        int n;
        e = ref_op(ins, a, b, imm);
        @(negedge clk);
        req_instr = ins; req_rs1 = a; req_rs2 = b; req_imm = imm;
        req_valid = 1'b1; rsp_ready = 1'b0;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (req_ready !== 1'b1) begin
            failures++; $display("FAIL %s accept_timeout req_ready=%b required=1", name, req_ready);
        end
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++; $display("FAIL %s early_rsp rsp_valid=%b required=0", name, rsp_valid);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1) begin
            failures++; $display("FAIL %s latency rsp_valid=%b required=1", name, rsp_valid);
        end
        checks++;
        if ({rsp_illegal, rsp_taken, rsp_data} !== e) begin
            failures++;
            $display("FAIL %s result ill/taken/data=%b/%b/%h required=%b/%b/%h",
                     name, rsp_illegal, rsp_taken, rsp_data, e[33], e[32], e[31:0]);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || {rsp_illegal, rsp_taken, rsp_data} !== e) begin
                failures++;
                $display("FAIL %s hold%0d valid/ill/taken/data=%b/%b/%b/%h required=1/%b/%b/%h",
                         name, h, rsp_valid, rsp_illegal, rsp_taken, rsp_data, e[33], e[32], e[31:0]);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
        exp_ops++;
        if (e[33]) exp_ill++;
        @(negedge clk);
        checks++;
        if (op_count !== exp_ops || illegal_count !== exp_ill || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s counters op/ill/valid=%0d/%0d/%b required=%0d/%0d/0",
                     name, op_count, illegal_count, rsp_valid, exp_ops, exp_ill);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || alu_f !== 3'b111 || alu_a !== 32'd0 || alu_b !== 32'd0 ||
            rsp_data !== 32'd0 || rsp_taken !== 1'b0 || rsp_illegal !== 1'b0 ||
            op_count !== '0 || illegal_count !== '0) begin
            failures++;
            $display("FAIL reset_values valid=%b f=%b a=%h b=%h data=%h taken=%b ill=%b ops=%0d ills=%0d required all 0 with f=111",
                     rsp_valid, alu_f, alu_a, alu_b, rsp_data, rsp_taken, rsp_illegal, op_count, illegal_count);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            failures++; $display("FAIL reset_ready req_ready=%b required=1", req_ready);
        end
        exp_ops = '0; exp_ill = '0;
    endtask

    task automatic test_directed();
        run_op("add", mk(7'h33, 3'd0, 7'h00), 32'd5, 32'd7, 32'd0, 0);
        checks++;
        if (alu_f !== 3'b000) begin
            failures++; $display("FAIL alu_f_hold alu_f=%b required=000", alu_f);
        end
        run_op("sub",  mk(7'h33, 3'd0, 7'h20), 32'd3, 32'd5, 32'd0, 0);
        run_op("addi", mk(7'h13, 3'd0, 7'h00), 32'd1, 32'd0, 32'hFFFFFFFF, 0);
        run_op("beq",  mk(7'h63, 3'd0, 7'h00), 32'd9, 32'd9, 32'd0, 0);
        run_op("bne",  mk(7'h63, 3'd1, 7'h00), 32'd9, 32'd9, 32'd0, 0);
        run_op("blt",  mk(7'h63, 3'd4, 7'h00), 32'hFFFFFFFF, 32'd1, 32'd0, 0);
        run_op("bge",  mk(7'h63, 3'd5, 7'h00), 32'hFFFFFFFF, 32'd1, 32'd0, 0);
    endtask

    task automatic test_illegal();
        run_op("illegal_op", mk(7'h7F, 3'd0, 7'h00), 32'd4, 32'd4, 32'd4, 3);
        run_op("illegal_f7", mk(7'h33, 3'd0, 7'h01), 32'd4, 32'd4, 32'd4, 0);
        run_op("illegal_bf3", mk(7'h63, 3'd2, 7'h00), 32'd4, 32'd4, 32'd4, 0);
    endtask

    task automatic test_random();
        logic [6:0]  ops [6];
        logic [31:0] ins;
        logic [31:0] a;
        logic [31:0] b;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h00};
        for (int i = 0; i < 30; i++) begin
            ins = $urandom;
            ins[6:0] = ops[$urandom_range(0, 5)];
            if (ins[6:0] == 7'h00) ins[6:0] = 7'($urandom);
            if (ins[6:0] == 7'h33 && $urandom_range(0, 3) != 0)
                ins[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            run_op("random", ins, a, b, $urandom, $urandom_range(0, 1));
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] expq [$];
        logic [31:0] e;
        logic [33:0] r;
        logic [2:0]  f3s [3];
        int acc;
        int got;
        int last_cyc;
        f3s = '{3'd0, 3'd4, 3'd7};
        acc = 0; got = 0; last_cyc = 0;
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && got < 10; cyc++) begin
            @(negedge clk);
            if (rsp_valid) begin
                e = expq.pop_front();
                checks++;
                if (rsp_data !== e) begin
                    failures++; $display("FAIL b2b_data%0d data=%h required=%h", got, rsp_data, e);
                end
                if (got > 0) begin
                    checks++;
                    if (cyc - last_cyc != 2) begin
                        failures++; $display("FAIL b2b_gap%0d gap=%0d required=2", got, cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
                got++;
                exp_ops++;
            end
            if (acc < 10) begin
                req_instr = mk(7'h33, f3s[$urandom_range(0, 2)], 7'h00);
                req_rs1 = $urandom; req_rs2 = $urandom;
                req_valid = 1'b1;
                if (req_ready) begin
                    r = ref_op(req_instr, req_rs1, req_rs2, req_imm);
                    expq.push_back(r[31:0]);
                    acc++;
                end
            end else begin
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        checks++;
        if (got != 10) begin
            failures++; $display("FAIL b2b_count responses=%0d required=10", got);
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (op_count !== exp_ops) begin
            failures++; $display("FAIL b2b_op_count op_count=%0d required=%0d", op_count, exp_ops);
        end
    endtask

    task automatic test_reset_mid_exec();
        int rose;
        @(negedge clk);
        req_instr = mk(7'h33, 3'd0, 7'h00); req_rs1 = 32'd1; req_rs2 = 32'd2; req_valid = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0; rst_n = 1'b0;
        exp_ops = '0; exp_ill = '0;
        rose = 0;
        repeat (2) begin @(negedge clk); if (rsp_valid) rose = 1; end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            failures++; $display("FAIL midreset_ready req_ready=%b required=1", req_ready);
        end
        repeat (3) begin @(negedge clk); if (rsp_valid) rose = 1; end
        checks++;
        if (rose != 0 || op_count !== '0 || illegal_count !== '0) begin
            failures++;
            $display("FAIL midreset_state rsp_rose=%0d ops=%0d ills=%0d required 0/0/0", rose, op_count, illegal_count);
        end
        run_op("post_reset_add", mk(7'h33, 3'd0, 7'h00), 32'd5, 32'd7, 32'd0, 0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_illegal();
        test_random();
        test_back_to_back();
        test_reset_mid_exec();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout sim_time=%0t required=finish", $time);
        $fatal(1);
    end

endmodule
